// File: rtl/hex_keypad_scan.sv
// rtl/hex_keypad_scan.sv - 4x4 hex keypad column scanner with sweep-level debounce and 8-digit history
module hex_keypad_scan #(
    parameter int SCAN_DIV       = 8192,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    input  logic        clear,
    output logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] data
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'h0;
            4'b11_01: k = 4'hF;
            4'b11_10: k = 4'hE;
            default:  k = 4'hD;
        endcase
        return k;
    endfunction

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic          sample;
    logic          sweep_done;

    // Rows reset to the idle (all-high) level so the first samples never look like presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
            col   <= 2'd0;
        end else if (dwell == DWELL_LAST) begin
            dwell <= '0;
            col   <= col + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign col_n      = ~(4'b0001 << col);
    assign sample     = (dwell == DWELL_LAST);
    assign sweep_done = sample && (col == 2'd3);

    logic [2:0] cur_pc;
    logic [1:0] cur_row;

    always_comb begin
        cur_pc  = 3'd0;
        cur_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                cur_pc  = cur_pc + 3'd1;
                cur_row = 2'(r);
            end
        end
    end

    // Hits from columns 0..2 accumulate here; column 3 is folded in combinationally at sweep end.
    logic [1:0] hit_cnt;
    logic [3:0] hit_code;
    logic [2:0] hit_sum;

    assign hit_sum = {1'b0, hit_cnt} + cur_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 2'd0;
            hit_code <= 4'h0;
        end else if (sample) begin
            if (col == 2'd3) begin
                hit_cnt <= 2'd0;
            end else begin
                hit_cnt <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
                if (hit_cnt == 2'd0 && cur_pc == 3'd1)
                    hit_code <= key_map(cur_row, col);
            end
        end
    end

    logic       is_none;
    logic       is_single;
    logic [3:0] sweep_code;

    assign is_none    = (hit_sum == 3'd0);
    assign is_single  = (hit_sum == 3'd1);
    assign sweep_code = (hit_cnt == 2'd1) ? hit_code : key_map(cur_row, 2'd3);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    cand, cand_n;
    logic [3:0]    code_q, code_n;
    logic [31:0]   data_q, data_n;
    logic          valid_q, valid_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cand    <= 4'h0;
            code_q  <= 4'h0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cand    <= cand_n;
            code_q  <= code_n;
            data_q  <= data_n;
            valid_q <= valid_n;
        end
    end

    // A MULTI sweep is neither SINGLE nor NONE, so it aborts a press but keeps a held key held.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = code_q;
        data_n  = data_q;
        valid_n = 1'b0;
        cnt_inc = cnt + CW'(1);
        if (sweep_done) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_n  = sweep_code;
                        cnt_n   = CW'(1);
                        state_n = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (is_single && sweep_code == cand) begin
                        if (cnt_inc == DB_LAST) begin
                            valid_n = 1'b1;
                            code_n  = cand;
                            data_n  = {data_q[27:0], cand};
                            state_n = PRESSED;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        cnt_n   = CW'(1);
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        if (cnt_inc == DB_LAST)
                            state_n = IDLE;
                        else
                            cnt_n = cnt_inc;
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (clear)
            data_n = valid_n ? {28'h0, cand} : 32'h0;
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = (state == PRESSED) || (state == RELEASE);
    assign data      = data_q;

endmodule

// File: tb/tb_hex_keypad_scan.sv
// tb/tb_hex_keypad_scan.sv - directed bench for hex_keypad_scan with a column-driven keypad model
module tb_hex_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic        clear;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] data;

    logic [3:0][3:0] keys;
    int passed = 0;
    int total = 0;
    int vld_count = 0;
    int base;

    hex_keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .clear     (clear),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .data      (data)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low while column c is strobed.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(keys[r] & ~col_n);
    end

    always @(posedge clk) begin
        #1;
        if (key_valid === 1'b1)
            vld_count = vld_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sweeps(input int n);
        cycles(16 * n);
    endtask

    initial begin
        logic [3:0] exp_col;
        rst_n = 1'b0;
        clear = 1'b0;
        keys  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_data", data, 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            check("col_seq", col_n, exp_col);
            cycles(1);
        end
        sweeps(2);
        check("idle_no_valid", vld_count, 0);
        check("idle_data", data, 32'h0);

        base = vld_count;
        keys[1][2] = 1'b1;
        sweeps(2);
        check("k6_not_yet", vld_count, base);
        check("k6_not_held", key_held, 1'b0);
        sweeps(1);
        check("k6_valid", key_valid, 1'b1);
        check("k6_code", key_code, 4'h6);
        check("k6_data", data, 32'h00000006);
        check("k6_held", key_held, 1'b1);
        cycles(1);
        check("k6_pulse_end", key_valid, 1'b0);
        cycles(15);
        sweeps(1);
        keys = '0;
        sweeps(2);
        check("k6_still_held", key_held, 1'b1);
        sweeps(1);
        check("k6_released", key_held, 1'b0);
        check("k6_one_pulse", vld_count, base + 1);

        for (int k = 1; k <= 9; k++) begin
            keys = '0;
            keys[(k - 1) / 3][(k - 1) % 3] = 1'b1;
            sweeps(4);
            keys = '0;
            sweeps(4);
        end
        check("seq_data", data, 32'h23456789);
        check("seq_code", key_code, 4'h9);
        check("seq_count", vld_count, base + 10);

        base = vld_count;
        keys[0][0] = 1'b1;
        sweeps(2);
        keys = '0;
        sweeps(1);
        keys[0][0] = 1'b1;
        sweeps(2);
        keys = '0;
        sweeps(3);
        check("glitch_no_valid", vld_count, base);
        check("glitch_not_held", key_held, 1'b0);

        keys[0][0] = 1'b1;
        keys[3][3] = 1'b1;
        sweeps(6);
        check("multi_no_valid", vld_count, base);
        check("multi_not_held", key_held, 1'b0);
        keys = '0;
        sweeps(1);

        keys[1][1] = 1'b1;
        sweeps(4);
        check("k5_count", vld_count, base + 1);
        check("k5_code", key_code, 4'h5);
        keys[3][0] = 1'b1;
        sweeps(4);
        check("add_key_no_valid", vld_count, base + 1);
        check("add_key_held", key_held, 1'b1);
        keys = '0;
        sweeps(4);
        check("k5_data", data, 32'h34567895);
        check("k5_released", key_held, 1'b0);

        keys[3][2] = 1'b1;
        sweeps(2);
        cycles(15);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("kE_valid", key_valid, 1'b1);
        check("kE_code", key_code, 4'hE);
        check("kE_clear_data", data, 32'h0000000E);
        cycles(15);
        keys = '0;
        sweeps(4);

        base = vld_count;
        keys[0][2] = 1'b1;
        sweeps(2);
        cycles(5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_col_n", col_n, 4'b1110);
        check("arst_key_valid", key_valid, 1'b0);
        check("arst_key_code", key_code, 4'h0);
        check("arst_key_held", key_held, 1'b0);
        check("arst_data", data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sweeps(2);
        check("rst_fresh_no_valid", vld_count, base);
        sweeps(1);
        check("k3_valid", key_valid, 1'b1);
        check("k3_code", key_code, 4'h3);
        check("k3_data", data, 32'h00000003);
        check("k3_count", vld_count, base + 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scan.md
HEX_KEYPAD_SCAN -- requirements
Module: hex_keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 8192, meaning clock cycles each column is strobed (legal >= 4).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical full sweeps needed to accept a press or a release (legal >= 2).
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port row_n  input  4  keypad rows, active-low, asynchronous to clk.
REQ-006 SHALL have port clear  input  1  synchronous pulse that zeroes data.
REQ-007 SHALL have port col_n  output  4  column strobe, active-low, exactly one bit low at a time.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a debounced press is accepted.
REQ-009 SHALL have port key_code  output  4  hex value of the last accepted key.
REQ-010 SHALL have port key_held  output  1  high while an accepted key has not yet been debounced as released.
REQ-011 SHALL have port data  output  32  last 8 accepted digits, most recent in [3:0], oldest in [31:28].

Function
REQ-012 SHALL pass row_n through a 2-flop synchronizer before any use.
REQ-013 SHALL hold each column for SCAN_DIV cycles using a dwell counter, then advance col_n 1110 -> 1101 -> 1011 -> 0111 -> 1110 (column index 0..3, wrapping).
REQ-014 SHALL sample the synchronized rows only on the last dwell cycle of each column (dwell count SCAN_DIV-1).
REQ-015 SHALL classify each sweep (columns 0..3) after column 3 is sampled as NONE (no row low), SINGLE (exactly one row/column intersection low), or MULTI (more than one); MULTI SHALL be treated as NONE for pressing and as a held key for releasing.
REQ-016 SHALL map row r, column c to key code: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D (c = 0..3, left to right).
REQ-017 SHALL run an FSM updated once per completed sweep, with states IDLE, DEBOUNCE, PRESSED, and RELEASE.
REQ-018 In IDLE, a SINGLE sweep SHALL latch the candidate code, set the match count to 1, and move to DEBOUNCE.
REQ-019 In DEBOUNCE, a SINGLE sweep with the same code SHALL increment the count; any other result SHALL return the FSM to IDLE.
REQ-020 When the count reaches DEBOUNCE_SCANS, the block SHALL pulse key_valid for one cycle, load key_code, shift data left 4 with the code inserted in [3:0], and move to PRESSED, all in the same cycle.
REQ-021 In PRESSED, a NONE sweep SHALL set the release count to 1 and move to RELEASE; any other result SHALL leave the FSM in PRESSED.
REQ-022 In RELEASE, a NONE sweep SHALL increment the count and return to IDLE at DEBOUNCE_SCANS; any other result SHALL return the FSM to PRESSED.
REQ-023 key_held SHALL be 1 exactly in PRESSED and RELEASE.
REQ-024 A held key SHALL never produce a second key_valid; auto-repeat is excluded.
REQ-025 clear SHALL set data to 0; when clear coincides with a key_valid acceptance, data SHALL become {28'h0, code}.
REQ-026 The scan counter SHALL free-run independent of FSM state.

Reset
REQ-027 While rst_n = 0, outputs SHALL be col_n = 4'b1110, key_valid = 0, key_code = 0, key_held = 0, data = 32'h0, FSM = IDLE, and all counters and synchronizers cleared.
REQ-028 Reset asserted mid-debounce or mid-press SHALL discard the candidate; after release, scanning SHALL restart at column 0 with a fresh sweep.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 3; one sweep = 16 cycles)
REQ-029 Reset release, no keys -> col_n cycles 1110, 1101, 1011, 0111 at 4 cycles each; key_valid never asserts; data = 0.
REQ-030 Hold row1/col2 low for 5 sweeps, then release -> exactly one key_valid pulse at the end of the 3rd sweep with key_code = 6 and data = 32'h00000006; key_held falls at the end of the 3rd NONE sweep.
REQ-031 Press keys 1 2 3 4 5 6 7 8 9 (each 4 sweeps, then 4 sweeps released) -> data = 32'h23456789.
REQ-032 Glitch: key present for 2 sweeps, absent for 1, present for 2 -> no key_valid.
REQ-033 Press r0/c0 and r3/c3 simultaneously for 6 sweeps -> no key_valid; a single key held with a second key added afterward -> no additional key_valid.
REQ-034 clear pulsed in the same cycle as acceptance of key E -> data = 32'h0000000E; assert rst_n = 0 mid-DEBOUNCE -> all outputs return to reset values asynchronously.
